// File: rtl/kv_pkg.sv
// Shared types and default sizes for the key-value store client.
package kv_pkg;

    // Lookup sequencer states
    typedef enum logic {
        KVC_IDLE = 1'b0,
        KVC_WAIT = 1'b1
    } kvc_state_t;

    localparam int KV_KEY_WIDTH_DFLT = 32;
    localparam int KV_VAL_WIDTH_DFLT = 32;
    localparam int KV_UPD_DEPTH_DFLT = 4;

endpackage

// File: rtl/kv_update_fifo.sv
// Update queue for the key-value client: a small circular FIFO of (key, value)
// pairs with a combinational search port that reports the youngest live entry
// whose key matches the search key.
module kv_update_fifo
    import kv_pkg::*;
#(
    parameter int KEY_WIDTH = KV_KEY_WIDTH_DFLT,
    parameter int VAL_WIDTH = KV_VAL_WIDTH_DFLT,
    parameter int DEPTH     = KV_UPD_DEPTH_DFLT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push_valid,
    input  logic [KEY_WIDTH-1:0] push_key,
    input  logic [VAL_WIDTH-1:0] push_value,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [KEY_WIDTH-1:0] head_key,
    output logic [VAL_WIDTH-1:0] head_value,
    input  logic [KEY_WIDTH-1:0] srch_key,
    output logic                 srch_hit,
    output logic [VAL_WIDTH-1:0] srch_value
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [KEY_WIDTH-1:0] key_mem_q [DEPTH];
    logic [KEY_WIDTH-1:0] key_mem_d [DEPTH];
    logic [VAL_WIDTH-1:0] val_mem_q [DEPTH];
    logic [VAL_WIDTH-1:0] val_mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 do_push;
    logic                 do_pop;
    logic [PTR_W-1:0]     srch_idx;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_key   = key_mem_q[rd_ptr_q];
    assign head_value = val_mem_q[rd_ptr_q];

    // A full queue refuses pushes even if it pops this cycle; the freed slot is usable next cycle.
    assign do_push = push_valid & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        key_mem_d = key_mem_q;
        val_mem_d = val_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push) begin
            key_mem_d[wr_ptr_q] = push_key;
            val_mem_d[wr_ptr_q] = push_value;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Walk live entries oldest to youngest so the last match found is the youngest
    always_comb begin
        srch_hit   = 1'b0;
        srch_value = '0;
        srch_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            srch_idx = rd_ptr_q + PTR_W'(i);
            if ((i < int'(count_q)) && (key_mem_q[srch_idx] == srch_key)) begin
                srch_hit   = 1'b1;
                srch_value = val_mem_q[srch_idx];
            end
        end
    end

    // Queue state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_mem_q[i] <= '0;
                val_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            key_mem_q <= key_mem_d;
            val_mem_q <= val_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/kv_lookup_client.sv
// Client of the 1-cycle direct-mapped key-value store. Issues one lookup at a
// time to the store, returns a registered result, and trickles queued table
// updates into the store on cycles where no lookup is being issued. Lookups
// see updates that are still queued through a bypass captured at issue time.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   KVC_IDLE | ready for a lookup; issues it to the store on accept
//   KVC_WAIT | lookup issued, waiting for the store response (or a flush)
module kv_lookup_client
    import kv_pkg::*;
#(
    parameter int KEY_WIDTH = KV_KEY_WIDTH_DFLT,
    parameter int VAL_WIDTH = KV_VAL_WIDTH_DFLT,
    parameter int UPD_DEPTH = KV_UPD_DEPTH_DFLT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lk_valid,
    output logic                 lk_ready,
    input  logic [KEY_WIDTH-1:0] lk_key,
    output logic                 res_valid,
    output logic                 res_hit,
    output logic [VAL_WIDTH-1:0] res_value,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [KEY_WIDTH-1:0] upd_key,
    input  logic [VAL_WIDTH-1:0] upd_value,
    input  logic                 flush,
    input  logic                 kvs_req_ready,
    output logic                 kvs_req_valid,
    output logic [KEY_WIDTH-1:0] kvs_req_key,
    input  logic                 kvs_resp_valid,
    input  logic                 kvs_resp_hit,
    input  logic [VAL_WIDTH-1:0] kvs_resp_value,
    output logic                 kvs_update_valid,
    output logic [KEY_WIDTH-1:0] kvs_update_key,
    output logic [VAL_WIDTH-1:0] kvs_update_value
);

    kvc_state_t           state_q, state_d;
    logic                 byp_hit_q, byp_hit_d;
    logic [VAL_WIDTH-1:0] byp_value_q, byp_value_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_hit_q, res_hit_d;
    logic [VAL_WIDTH-1:0] res_value_q, res_value_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [KEY_WIDTH-1:0] head_key;
    logic [VAL_WIDTH-1:0] head_value;
    logic                 srch_hit;
    logic [VAL_WIDTH-1:0] srch_value;

    logic                 force_drain;
    logic                 accept;
    logic                 drain;
    logic                 push;

    // Searching on lk_key directly means the bypass reflects entries present
    // at the start of the accept cycle; a same-cycle enqueue is not visible.
    kv_update_fifo #(
        .KEY_WIDTH (KEY_WIDTH),
        .VAL_WIDTH (VAL_WIDTH),
        .DEPTH     (UPD_DEPTH)
    ) u_upd_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (push),
        .push_key   (upd_key),
        .push_value (upd_value),
        .pop        (drain),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_key   (head_key),
        .head_value (head_value),
        .srch_key   (lk_key),
        .srch_hit   (srch_hit),
        .srch_value (srch_value)
    );

    // Arbitration: a lookup owns the store port in its accept cycle, otherwise the queue head drains.
    // Handshake outputs are held low while reset_n is asserted.
    always_comb begin
        force_drain      = fifo_full;
        lk_ready         = reset_n & (state_q == KVC_IDLE) & kvs_req_ready & ~force_drain & ~flush;
        accept           = lk_valid & lk_ready;
        kvs_req_valid    = accept;
        kvs_req_key      = accept ? lk_key : '0;
        drain            = ~fifo_empty & ~accept;
        kvs_update_valid = drain;
        kvs_update_key   = drain ? head_key : '0;
        kvs_update_value = drain ? head_value : '0;
        upd_ready        = reset_n & ~fifo_full;
        push             = upd_valid & upd_ready;
    end

    // Lookup sequencer next-state and result formation
    always_comb begin
        state_d     = state_q;
        byp_hit_d   = byp_hit_q;
        byp_value_d = byp_value_q;
        res_valid_d = 1'b0;
        res_hit_d   = res_hit_q;
        res_value_d = res_value_q;
        unique case (state_q)
            KVC_IDLE: begin
                if (accept) begin
                    byp_hit_d   = srch_hit;
                    byp_value_d = srch_value;
                    state_d     = KVC_WAIT;
                end
            end
            KVC_WAIT: begin
                // A response arriving alongside a flush belongs to the dropped lookup.
                if (flush) begin
                    state_d = KVC_IDLE;
                end else if (kvs_resp_valid) begin
                    res_valid_d = 1'b1;
                    if (byp_hit_q) begin
                        res_hit_d   = 1'b1;
                        res_value_d = byp_value_q;
                    end else begin
                        res_hit_d   = kvs_resp_hit;
                        res_value_d = kvs_resp_hit ? kvs_resp_value : '0;
                    end
                    state_d = KVC_IDLE;
                end
            end
            default: state_d = KVC_IDLE;
        endcase
    end

    // Sequencer state, bypass capture and registered result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= KVC_IDLE;
            byp_hit_q   <= 1'b0;
            byp_value_q <= '0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_value_q <= '0;
        end else begin
            state_q     <= state_d;
            byp_hit_q   <= byp_hit_d;
            byp_value_q <= byp_value_d;
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            res_value_q <= res_value_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_hit   = res_hit_q;
    assign res_value = res_value_q;

endmodule

// File: tb/tb_kv_lookup_client.sv
// Bench for kv_lookup_client: a behavioural 1-cycle store, a reference map of
// all accepted updates, and a scoreboard of expected lookup results.
module tb_kv_lookup_client;

    logic        clk;
    logic        reset_n;
    logic        lk_valid;
    logic        lk_ready;
    logic [31:0] lk_key;
    logic        res_valid;
    logic        res_hit;
    logic [31:0] res_value;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_key;
    logic [31:0] upd_value;
    logic        flush;
    logic        kvs_req_ready;
    logic        kvs_req_valid;
    logic [31:0] kvs_req_key;
    logic        kvs_resp_valid;
    logic        kvs_resp_hit;
    logic [31:0] kvs_resp_value;
    logic        kvs_update_valid;
    logic [31:0] kvs_update_key;
    logic [31:0] kvs_update_value;

    logic        resp_en;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic        hit;
        logic [31:0] value;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] ref_map [logic [31:0]];
    logic [31:0] st_mem  [logic [31:0]];
    logic        model_wait;

    kv_lookup_client #(
        .KEY_WIDTH (32),
        .VAL_WIDTH (32),
        .UPD_DEPTH (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .lk_valid         (lk_valid),
        .lk_ready         (lk_ready),
        .lk_key           (lk_key),
        .res_valid        (res_valid),
        .res_hit          (res_hit),
        .res_value        (res_value),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_key          (upd_key),
        .upd_value        (upd_value),
        .flush            (flush),
        .kvs_req_ready    (kvs_req_ready),
        .kvs_req_valid    (kvs_req_valid),
        .kvs_req_key      (kvs_req_key),
        .kvs_resp_valid   (kvs_resp_valid),
        .kvs_resp_hit     (kvs_resp_hit),
        .kvs_resp_value   (kvs_resp_value),
        .kvs_update_valid (kvs_update_valid),
        .kvs_update_key   (kvs_update_key),
        .kvs_update_value (kvs_update_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store model: 1-cycle read, garbage value on miss so the client must mask it
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kvs_resp_valid <= 1'b0;
            kvs_resp_hit   <= 1'b0;
            kvs_resp_value <= 32'h0;
            st_mem.delete();
        end else begin
            kvs_resp_valid <= kvs_req_valid & resp_en;
            if (kvs_req_valid && st_mem.exists(kvs_req_key)) begin
                kvs_resp_hit   <= 1'b1;
                kvs_resp_value <= st_mem[kvs_req_key];
            end else begin
                kvs_resp_hit   <= 1'b0;
                kvs_resp_value <= 32'hDEAD_BEEF;
            end
            if (kvs_update_valid) st_mem[kvs_update_key] = kvs_update_value;
        end
    end

    // Scoreboard: a lookup must return the newest update accepted before the lookup's accept cycle
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            expq.delete();
            ref_map.delete();
            model_wait = 1'b0;
        end else begin
            n_tests++;
            if (kvs_req_valid && kvs_update_valid) begin
                n_fail++;
                $display("FAIL req_update_overlap: req_valid=%0b update_valid=%0b at %0t", kvs_req_valid, kvs_update_valid, $time);
            end
            if (res_valid) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_res: res_valid=1 with nothing outstanding at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    if (res_hit !== e.hit || res_value !== e.value) begin
                        n_fail++;
                        $display("FAIL sb_result: got hit=%0b val=%0h expected hit=%0b val=%0h at %0t", res_hit, res_value, e.hit, e.value, $time);
                    end
                end
            end
            if (model_wait) begin
                if (flush) begin
                    if (expq.size() != 0) void'(expq.pop_back());
                    model_wait = 1'b0;
                end else if (kvs_resp_valid) begin
                    model_wait = 1'b0;
                end
            end
            if (lk_valid && lk_ready) begin
                e.hit   = ref_map.exists(lk_key);
                e.value = e.hit ? ref_map[lk_key] : 32'h0;
                expq.push_back(e);
                model_wait = 1'b1;
            end
            if (upd_valid && upd_ready) ref_map[upd_key] = upd_value;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lk_valid  = 1'b0;
        lk_key    = 32'h0;
        upd_valid = 1'b0;
        upd_key   = 32'h0;
        upd_value = 32'h0;
        flush     = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    task automatic wait_res(input int max_cyc, output logic got, output logic hit, output logic [31:0] val);
        got = 1'b0;
        hit = 1'b0;
        val = 32'h0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                hit = res_hit;
                val = res_value;
            end
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        kvs_req_ready = 1'b1;
        resp_en       = 1'b1;
        clear_inputs();
        lk_valid  = 1'b1;
        lk_key    = 32'h40;
        upd_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (lk_ready !== 1'b0 || kvs_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: lk_ready=%0b req_valid=%0b expected 0", lk_ready, kvs_req_valid);
        end
        n_tests++;
        if (res_valid !== 1'b0 || res_hit !== 1'b0 || res_value !== 32'h0 || kvs_update_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: res_valid=%0b res_hit=%0b res_value=%0h upd_valid=%0b expected all 0", res_valid, res_hit, res_value, kvs_update_valid);
        end
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if (lk_ready !== 1'b1 || upd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: lk_ready=%0b upd_ready=%0b expected 1", lk_ready, upd_ready);
        end
    endtask

    task automatic test_miss();
        logic got, hit;
        logic [31:0] val;
        tick();
        lk_valid = 1'b1;
        lk_key   = 32'h40;
        @(negedge clk);
        n_tests++;
        if (lk_ready !== 1'b1 || kvs_req_valid !== 1'b1 || kvs_req_key !== 32'h40) begin
            n_fail++;
            $display("FAIL miss_accept: lk_ready=%0b req_valid=%0b req_key=%0h expected 1 1 40", lk_ready, kvs_req_valid, kvs_req_key);
        end
        tick();
        lk_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_early: res_valid=%0b one cycle after accept, expected 0", res_valid);
        end
        tick();
        @(negedge clk);
        got = res_valid; hit = res_hit; val = res_value;
        n_tests++;
        if (got !== 1'b1 || hit !== 1'b0 || val !== 32'h0) begin
            n_fail++;
            $display("FAIL miss_result: valid=%0b hit=%0b val=%0h expected 1 0 0", got, hit, val);
        end
        idle(2);
    endtask

    task automatic test_same_cycle();
        logic got, hit;
        logic [31:0] val;
        tick();
        upd_valid = 1'b1; upd_key = 32'h40; upd_value = 32'hAAAA;
        lk_valid  = 1'b1; lk_key  = 32'h40;
        @(negedge clk);
        n_tests++;
        if (kvs_req_valid !== 1'b1 || kvs_update_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_req_first: req_valid=%0b update_valid=%0b expected 1 0", kvs_req_valid, kvs_update_valid);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (kvs_update_valid !== 1'b1 || kvs_update_key !== 32'h40 || kvs_update_value !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL same_cycle_drain: valid=%0b key=%0h val=%0h expected 1 40 aaaa", kvs_update_valid, kvs_update_key, kvs_update_value);
        end
        wait_res(4, got, hit, val);
        n_tests++;
        if (got !== 1'b1 || hit !== 1'b0 || val !== 32'h0) begin
            n_fail++;
            $display("FAIL same_cycle_no_bypass: valid=%0b hit=%0b val=%0h expected 1 0 0", got, hit, val);
        end
        idle(3);
    endtask

    task automatic test_bypass_youngest();
        logic [31:0] ks [4] = '{32'h50, 32'h51, 32'h40, 32'h40};
        logic [31:0] vs [4] = '{32'h5, 32'h6, 32'h1111, 32'h2222};
        int          nres = 0;
        logic        last_hit = 1'b0;
        logic [31:0] last_val = 32'h0;
        for (int c = 0; c < 8; c++) begin
            tick();
            upd_valid = (c < 4);
            if (c < 4) begin
                upd_key   = ks[c];
                upd_value = vs[c];
            end
            lk_valid = (c < 5);
            lk_key   = 32'h40;
            @(negedge clk);
            if (res_valid) begin
                nres++;
                last_hit = res_hit;
                last_val = res_value;
            end
        end
        n_tests++;
        if (nres != 3) begin
            n_fail++;
            $display("FAIL youngest_count: got %0d results expected 3", nres);
        end
        n_tests++;
        if (last_hit !== 1'b1 || last_val !== 32'h2222) begin
            n_fail++;
            $display("FAIL youngest_bypass: hit=%0b val=%0h expected 1 2222", last_hit, last_val);
        end
        idle(6);
    endtask

    task automatic test_fill();
        logic saw_full = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            lk_valid  = 1'b1;
            lk_key    = 32'h100 + 32'(c % 2);
            upd_valid = 1'b1;
            upd_key   = 32'h100 + 32'(c % 3);
            upd_value = 32'hF000 + 32'(c);
            @(negedge clk);
            if (!upd_ready) saw_full = 1'b1;
            n_tests++;
            if (!upd_ready && lk_ready) begin
                n_fail++;
                $display("FAIL fill_force_drain: lk_ready=%0b while upd_ready=%0b", lk_ready, upd_ready);
            end
        end
        idle(10);
        n_tests++;
        if (saw_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_reached_full: saw_full=%0b expected 1", saw_full);
        end
    endtask

    task automatic test_flush();
        logic got, hit;
        logic [31:0] val;
        tick();
        upd_valid = 1'b1; upd_key = 32'h80; upd_value = 32'h8080;
        tick();
        clear_inputs();
        idle(3);
        lk_valid = 1'b1; lk_key = 32'h90;
        @(negedge clk);
        n_tests++;
        if (kvs_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_accept: req_valid=%0b expected 1", kvs_req_valid);
        end
        tick();
        lk_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_suppress: res_valid=%0b expected 0 (cycle %0d)", res_valid, c);
            end
            tick();
        end
        flush    = 1'b1;
        lk_valid = 1'b1;
        lk_key   = 32'h80;
        @(negedge clk);
        n_tests++;
        if (lk_ready !== 1'b0 || kvs_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_block: lk_ready=%0b req_valid=%0b expected 0 0", lk_ready, kvs_req_valid);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (kvs_req_valid !== 1'b1 || kvs_req_key !== 32'h80) begin
            n_fail++;
            $display("FAIL flush_next_accept: req_valid=%0b key=%0h expected 1 80", kvs_req_valid, kvs_req_key);
        end
        tick();
        lk_valid = 1'b0;
        wait_res(4, got, hit, val);
        n_tests++;
        if (got !== 1'b1 || hit !== 1'b1 || val !== 32'h8080) begin
            n_fail++;
            $display("FAIL flush_next_result: valid=%0b hit=%0b val=%0h expected 1 1 8080", got, hit, val);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_wait();
        logic got, hit;
        logic [31:0] val;
        for (int c = 0; c < 5; c++) begin
            tick();
            lk_valid  = 1'b1;
            lk_key    = 32'h200;
            upd_valid = 1'b1;
            upd_key   = 32'h300 + 32'(c);
            upd_value = 32'h3000 + 32'(c);
        end
        tick();
        clear_inputs();
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (res_valid !== 1'b0 || res_hit !== 1'b0 || res_value !== 32'h0 || lk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_res: res_valid=%0b hit=%0b val=%0h lk_ready=%0b expected all 0", res_valid, res_hit, res_value, lk_ready);
        end
        n_tests++;
        if (kvs_req_valid !== 1'b0 || kvs_req_key !== 32'h0 || kvs_update_valid !== 1'b0 || kvs_update_key !== 32'h0 || kvs_update_value !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_kvs: req_valid=%0b req_key=%0h upd_valid=%0b upd_key=%0h upd_val=%0h expected all 0", kvs_req_valid, kvs_req_key, kvs_update_valid, kvs_update_key, kvs_update_value);
        end
        tick();
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (kvs_update_valid !== 1'b0 || res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_drain: update_valid=%0b res_valid=%0b expected 0 0 (cycle %0d)", kvs_update_valid, res_valid, c);
            end
            tick();
        end
        lk_valid = 1'b1;
        lk_key   = 32'h300;
        tick();
        lk_valid = 1'b0;
        wait_res(4, got, hit, val);
        n_tests++;
        if (got !== 1'b1 || hit !== 1'b0 || val !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_queue_dropped: valid=%0b hit=%0b val=%0h expected 1 0 0", got, hit, val);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            tick();
            lk_valid      = 1'($urandom_range(0, 1));
            lk_key        = 32'h400 + 32'($urandom_range(0, 3));
            upd_valid     = ($urandom_range(0, 2) != 0);
            upd_key       = 32'h400 + 32'($urandom_range(0, 3));
            upd_value     = $urandom;
            kvs_req_ready = ($urandom_range(0, 3) != 0);
            resp_en       = ($urandom_range(0, 7) != 0);
            flush         = ($urandom_range(0, 11) == 0);
        end
        tick();
        clear_inputs();
        kvs_req_ready = 1'b1;
        resp_en       = 1'b1;
        flush         = 1'b1;
        tick();
        idle(10);
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_outstanding: %0d results never returned, expected 0", expq.size());
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        model_wait = 1'b0;
        test_reset();
        test_miss();
        test_same_cycle();
        test_bypass_youngest();
        test_fill();
        test_flush();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
